enemy_bullet_pool: RTL
======================

ENEMY_BULLET_POOL -- requirements
Module: enemy_bullet_pool

Interface
REQ-001 SHALL have parameters: NUM_SLOTS, default 4, bullet slot count (1..16); FIRE_PERIOD, default 480, ticks between shots; SPEED, default 1, pixels moved per tick; BW, default 10, bullet width; BH, default 40, bullet height; X_OFF, default 23, spawn x offset; Y_OFF, default 40, spawn y offset; COLOR, default 12'hFFF, bullet colour.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 tick  in  1  one-cycle game-step strobe, replacing the old second clock domain.
REQ-006 ep_x, ep_y  in  10 each  enemy plane top-left.
REQ-007 enemyplane_exist  in  1  high while the enemy plane is alive.
REQ-008 hit_valid  in  1  collision report strobe; hit_idx  in  $clog2(NUM_SLOTS)  slot that collided.
REQ-009 x, y  in  10 each  VGA scan pixel.
REQ-010 active  out  NUM_SLOTS  per-slot live mask.
REQ-011 eb_x, eb_y  out  NUM_SLOTS*10 each  packed slot positions, slot 0 in the LSBs.
REQ-012 pix_en  out  1  registered: scan pixel lies inside a live bullet.
REQ-013 pix_idx  out  $clog2(NUM_SLOTS)  registered index of the lowest-numbered hit slot.
REQ-014 pix_rgb  out  12  COLOR when pix_en is high, else 0.
REQ-015 fire  out  1  one-cycle pulse on a successful spawn; drop  out  1  one-cycle pulse when a shot is due but no slot is free.

Function
REQ-016 State changes only in cycles where tick=1, except hit handling (REQ-021) and pixel outputs.
REQ-017 Fire counter, 10 bits: on tick, when counter==FIRE_PERIOD-1 it wraps to 0 and a shot is due; otherwise it increments.
REQ-018 When a shot is due, enemyplane_exist=1, and ep_y+Y_OFF<480 (computed at 11 bits), the lowest-index inactive slot SHALL load (ep_x+X_OFF, ep_y+Y_OFF), become active, and fire SHALL pulse.
REQ-019 Shot due, enemy alive, all slots active: drop pulses and no state changes. Shot due with enemy dead or spawn y out of range: neither fire nor drop pulses.
REQ-020 On tick, every active slot not spawning this cycle SHALL add SPEED to eb_y; a slot whose eb_y+SPEED (11-bit) exceeds 479 SHALL deactivate instead of moving. No 10-bit wrap is permitted.
REQ-021 hit_valid with an active hit_idx SHALL clear that slot on the same edge, with priority over movement. A hit on an inactive slot, or an hit_idx >= NUM_SLOTS, SHALL be ignored.
REQ-022 A slot cleared by a hit in cycle N SHALL NOT be eligible for a spawn in cycle N; it becomes eligible from cycle N+1.
REQ-023 enemyplane_exist falling SHALL NOT clear in-flight bullets; they continue until they leave the screen or are hit.
REQ-024 A slot hits the scan pixel when active, eb_x<=x<eb_x+BW, and eb_y<=y<eb_y+BH, all at 11 bits. pix_en, pix_idx and pix_rgb SHALL be registered with 1-cycle latency from x/y.
REQ-025 Inactive slots SHALL hold their last position; the positions of inactive slots are don't-care to consumers.

Reset
REQ-026 When rst=0 at an edge: active=0, all eb_x/eb_y=0, counter=0, pix_en=0, pix_idx=0, pix_rgb=0, fire=0, drop=0.
REQ-027 Reset applied mid-flight SHALL take effect on the next edge, discarding all bullets. The first shot SHALL be due at tick number FIRE_PERIOD after reset release.

Structure
REQ-028 Package enemy_bullet_pkg SHALL hold COORD_W=10, SCREEN_W=640, SCREEN_H=480 and the default colour constant.
REQ-029 Sub-module enemy_bullet_slot SHALL be instantiated NUM_SLOTS times in a generate loop. Each instance holds active/x/y, applies spawn/move/hit, and outputs its own pixel-hit bit.
REQ-030 Free-slot selection and pixel-hit selection SHALL each be a lowest-index priority encoder in the top level.

Verification
REQ-031 Reset: rst=0 for 2 cycles, then tick for FIRE_PERIOD-1 ticks -> no fire. The next tick -> fire=1 and slot 0 at (ep_x+23, ep_y+40).
REQ-032 Movement/exit: SPEED=1, spawn at y=440 -> slot at y=479 after 39 ticks. The next tick clears active[0], with no wrap to 0.
REQ-033 Saturation: NUM_SLOTS=2, FIRE_PERIOD=4, no hits -> slots 0 and 1 fill. The third due shot -> drop=1, fire=0.
REQ-034 Hit/spawn race: all slots full, hit_idx=1 in the same cycle a shot is due -> slot 1 cleared and drop=1. The next due shot -> spawns into slot 1.
REQ-035 Pixel: bullet at (100,200), scan (109,239) -> pix_en=1 one cycle later. Scan (110,239) or (109,240) -> pix_en=0.
REQ-036 Enemy death: enemyplane_exist=0 with 2 bullets in flight -> both keep moving, and no fire or drop occurs for due shots.

Source files
------------

// File: rtl/enemy_bullet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enemy_bullet_pkg
// Purpose  : Shared constants and helpers for the enemy bullet pool.
//            COORD_W    - width of a screen coordinate
//            SCREEN_W/H - visible VGA area
//            DEFAULT_COLOR - bullet colour used when none is given
// Revision : 1.0 - initial release
// ============================================================================
package enemy_bullet_pkg;

  localparam int          COORD_W       = 10;
  localparam int          SCREEN_W      = 640;
  localparam int          SCREEN_H      = 480;
  localparam logic [11:0] DEFAULT_COLOR = 12'hFFF;

  // Index width for a slot count; a single slot still gets a 1-bit index
  // so that no port collapses to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_bullet_slot.sv
`default_nettype none
// ============================================================================
// Module   : enemy_bullet_slot
// Purpose  : One bullet slot: holds live flag and position, applies spawn,
//            downward movement, off-screen retirement and hit clearing, and
//            reports whether the current scan pixel lies inside the bullet.
// Ports    : clk, rst          - clock, synchronous active-low reset
//            i_tick            - game-step strobe
//            i_spawn           - load spawn position on this tick
//            i_spawn_x/y       - spawn position
//            i_hit             - clear the slot (independent of tick)
//            i_x, i_y          - VGA scan pixel
//            o_active, o_x/o_y - slot state
//            o_pix_hit         - scan pixel inside this live bullet
// Revision : 1.0 - initial release
// ============================================================================
module enemy_bullet_slot
  import enemy_bullet_pkg::*;
#(
  parameter int SPEED = 1,
  parameter int BW    = 10,
  parameter int BH    = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_spawn,
  input  logic [COORD_W-1:0] i_spawn_x,
  input  logic [COORD_W-1:0] i_spawn_y,
  input  logic               i_hit,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_active,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_pix_hit
);

  localparam int WW = COORD_W + 1;

  logic               r_active;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  logic [WW-1:0] w_next_y;
  logic [WW-1:0] w_x11;
  logic [WW-1:0] w_y11;
  logic [WW-1:0] w_bx11;
  logic [WW-1:0] w_by11;

  // Movement is evaluated one bit wider so a bullet near the bottom edge
  // retires instead of wrapping back to the top.
  assign w_next_y = {1'b0, r_y} + WW'(SPEED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (i_hit) begin
      // Hit wins over movement; position is left as-is.
      r_active <= 1'b0;
    end else if (i_tick) begin
      if (i_spawn) begin
        r_active <= 1'b1;
        r_x      <= i_spawn_x;
        r_y      <= i_spawn_y;
      end else if (r_active) begin
        if (w_next_y > WW'(SCREEN_H - 1)) begin
          r_active <= 1'b0;
        end else begin
          r_y <= w_next_y[COORD_W-1:0];
        end
      end
    end
  end

  assign w_x11  = {1'b0, i_x};
  assign w_y11  = {1'b0, i_y};
  assign w_bx11 = {1'b0, r_x};
  assign w_by11 = {1'b0, r_y};

  assign o_pix_hit = r_active
                   && (w_x11 >= w_bx11) && (w_x11 < w_bx11 + WW'(BW))
                   && (w_y11 >= w_by11) && (w_y11 < w_by11 + WW'(BH));

  assign o_active = r_active;
  assign o_x      = r_x;
  assign o_y      = r_y;

endmodule
`default_nettype wire

// File: rtl/enemy_bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : enemy_bullet_pool
// Purpose  : Pool of NUM_SLOTS enemy bullets. A fire counter advancing on
//            each tick schedules shots from the enemy plane into the lowest
//            free slot; bullets fall at SPEED per tick, retire at the bottom
//            of the screen or when hit, and are rendered onto the VGA scan.
// Ports    : clk, rst              - clock, synchronous active-low reset
//            tick                  - one-cycle game-step strobe
//            ep_x, ep_y            - enemy plane top-left
//            enemyplane_exist      - enemy plane alive
//            hit_valid, hit_idx    - collision report for one slot
//            x, y                  - VGA scan pixel
//            active                - per-slot live mask
//            eb_x, eb_y            - packed slot positions (slot 0 in LSBs)
//            pix_en/pix_idx/pix_rgb- registered pixel hit, slot, colour
//            fire, drop            - spawn pulse / shot lost to full pool
// Revision : 1.0 - initial release
// ============================================================================
module enemy_bullet_pool
  import enemy_bullet_pkg::*;
#(
  parameter int          NUM_SLOTS   = 4,
  parameter int          FIRE_PERIOD = 480,
  parameter int          SPEED       = 1,
  parameter int          BW          = 10,
  parameter int          BH          = 40,
  parameter int          X_OFF       = 23,
  parameter int          Y_OFF       = 40,
  parameter logic [11:0] COLOR       = DEFAULT_COLOR
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic [COORD_W-1:0]             ep_x,
  input  logic [COORD_W-1:0]             ep_y,
  input  logic                           enemyplane_exist,
  input  logic                           hit_valid,
  input  logic [idx_w(NUM_SLOTS)-1:0]    hit_idx,
  input  logic [COORD_W-1:0]             x,
  input  logic [COORD_W-1:0]             y,
  output logic [NUM_SLOTS-1:0]           active,
  output logic [NUM_SLOTS*COORD_W-1:0]   eb_x,
  output logic [NUM_SLOTS*COORD_W-1:0]   eb_y,
  output logic                           pix_en,
  output logic [idx_w(NUM_SLOTS)-1:0]    pix_idx,
  output logic [11:0]                    pix_rgb,
  output logic                           fire,
  output logic                           drop
);

  localparam int              IDX_W       = idx_w(NUM_SLOTS);
  localparam int              CNT_W       = 10;
  localparam int              WW          = COORD_W + 1;
  localparam logic [CNT_W-1:0] C_FIRE_LAST = CNT_W'(FIRE_PERIOD - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_fire;
  logic                 r_drop;
  logic                 r_pix_en;
  logic [IDX_W-1:0]     r_pix_idx;
  logic [11:0]          r_pix_rgb;

  logic [NUM_SLOTS-1:0] w_active;
  logic [NUM_SLOTS-1:0] w_pix_hit;
  logic                 w_due;
  logic [WW-1:0]        w_spawn_y11;
  logic [COORD_W-1:0]   w_spawn_x;
  logic                 w_y_ok;
  logic                 w_shot_ok;
  logic                 w_spawn_ok;
  logic                 w_free_any;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_pix_any;
  logic [IDX_W-1:0]     w_pix_sel;

  // --------------------------------------------------------------------------
  // Fire scheduling
  // --------------------------------------------------------------------------
  assign w_due       = tick && (r_cnt == C_FIRE_LAST);
  assign w_spawn_y11 = {1'b0, ep_y} + WW'(Y_OFF);
  assign w_spawn_x   = ep_x + COORD_W'(X_OFF);
  assign w_y_ok      = (w_spawn_y11 < WW'(SCREEN_H));
  assign w_shot_ok   = w_due && enemyplane_exist && w_y_ok;
  assign w_spawn_ok  = w_shot_ok && w_free_any;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= (r_cnt == C_FIRE_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Lowest-index free slot. A slot being cleared by a hit this cycle is
  // still active here, so it only becomes eligible on the next cycle.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!w_active[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Slots
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic w_spawn_i;
    logic w_hit_i;

    assign w_spawn_i = w_spawn_ok && (w_free_idx == IDX_W'(gi));
    // Out-of-range indices never match, and hits on idle slots are dropped.
    assign w_hit_i   = hit_valid && (hit_idx == IDX_W'(gi)) && w_active[gi];

    enemy_bullet_slot #(
      .SPEED (SPEED),
      .BW    (BW),
      .BH    (BH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .i_tick    (tick),
      .i_spawn   (w_spawn_i),
      .i_spawn_x (w_spawn_x),
      .i_spawn_y (w_spawn_y11[COORD_W-1:0]),
      .i_hit     (w_hit_i),
      .i_x       (x),
      .i_y       (y),
      .o_active  (w_active[gi]),
      .o_x       (eb_x[gi*COORD_W +: COORD_W]),
      .o_y       (eb_y[gi*COORD_W +: COORD_W]),
      .o_pix_hit (w_pix_hit[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Pixel output: lowest-index overlapping bullet, one cycle of latency
  // --------------------------------------------------------------------------
  always_comb begin
    w_pix_any = 1'b0;
    w_pix_sel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_pix_hit[i]) begin
        w_pix_any = 1'b1;
        w_pix_sel = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pix_en  <= 1'b0;
      r_pix_idx <= '0;
      r_pix_rgb <= '0;
      r_fire    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_pix_en  <= w_pix_any;
      r_pix_idx <= w_pix_sel;
      r_pix_rgb <= w_pix_any ? COLOR : 12'h000;
      r_fire    <= w_spawn_ok;
      r_drop    <= w_shot_ok && !w_free_any;
    end
  end

  assign active  = w_active;
  assign pix_en  = r_pix_en;
  assign pix_idx = r_pix_idx;
  assign pix_rgb = r_pix_rgb;
  assign fire    = r_fire;
  assign drop    = r_drop;

endmodule
`default_nettype wire
